// File: rtl/alu_secuencial_pkg.sv
// alu_secuencial shared types: opcodes, FSM states, flag bit positions.
// Build option ALU_SECUENCIAL_MUL_EN enables the shift-add multiplier.
package alu_secuencial_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_ADD  = 3'b011,
    OP_SUB  = 3'b100,
    OP_MUL  = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/mult_secuencial.sv
// Unsigned shift-add multiplier, one partial product per clock.
// The first step runs on the start cycle; done is high on the Nth cycle.
module mult_secuencial
  import alu_secuencial_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N_BITS-1:0]     a,
  input  logic [N_BITS-1:0]     b,
  output logic                  done,
  output logic [2*N_BITS-1:0]   product
);

  localparam int CW = $clog2(N_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(N_BITS);

  logic [N_BITS-1:0] mcand_q, mcand_d;
  logic [N_BITS-1:0] hi_q, hi_d;
  logic [N_BITS-1:0] lo_q, lo_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              run_q, run_d;

  logic [N_BITS-1:0] src_m;
  logic [N_BITS-1:0] src_hi;
  logic [N_BITS-1:0] src_lo;
  logic [N_BITS:0]   sum;

  // One add-and-shift step, fed from the ports on the start cycle
  always_comb begin
    src_m  = start ? a  : mcand_q;
    src_hi = start ? '0 : hi_q;
    src_lo = start ? b  : lo_q;
    sum    = {1'b0, src_hi}
           + (src_lo[0] ? {1'b0, src_m} : '0);
  end

  // Step sequencing and iteration count
  always_comb begin
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    if (start) begin
      mcand_d = a;
      hi_d    = sum[N_BITS:1];
      lo_d    = {sum[0], src_lo[N_BITS-1:1]};
      cnt_d   = CW'(1);
      run_d   = 1'b1;
    end else if (run_q) begin
      if (cnt_q == LAST) begin
        run_d = 1'b0;
      end else begin
        hi_d  = sum[N_BITS:1];
        lo_d  = {sum[0], src_lo[N_BITS-1:1]};
        cnt_d = cnt_q + 1'b1;
      end
    end
    done    = run_q && (cnt_q == LAST);
    product = {hi_q, lo_q};
  end

  // Multiplier state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
    end
  end

endmodule

// File: rtl/alu_secuencial.sv
// Handshaked ALU: logic/add/sub in one cycle, MUL via mult_secuencial.
// Define ALU_SECUENCIAL_MUL_EN to build the multiplier and BUSY path.
module alu_secuencial
  import alu_secuencial_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BITS-1:0] entrada_a,
  input  logic [N_BITS-1:0] entrada_b,
  input  logic [2:0]        operacion,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [N_BITS-1:0] resultado,
  output logic [N_BITS-1:0] resultado_alto,
  output logic [3:0]        banderas,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int MSB = N_BITS - 1;

  state_e            state_q, state_d;
  logic [N_BITS-1:0] res_q, res_d;
  logic [N_BITS-1:0] hi_q, hi_d;
  logic [3:0]        flg_q, flg_d;

  logic [N_BITS:0]   add_w;
  logic [N_BITS:0]   sub_w;
  logic [N_BITS-1:0] alu_res;
  logic [3:0]        alu_flg;

`ifdef ALU_SECUENCIAL_MUL_EN
  logic                mul_start;
  logic                mul_done;
  logic [2*N_BITS-1:0] mul_prod;

  mult_secuencial #(
    .N_BITS (N_BITS)
  ) u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (entrada_a),
    .b       (entrada_b),
    .done    (mul_done),
    .product (mul_prod)
  );
`endif

  // Single-cycle datapath; reserved opcodes fall out as 0 with Z set
  always_comb begin
    add_w   = {1'b0, entrada_a} + {1'b0, entrada_b};
    sub_w   = {1'b0, entrada_a} - {1'b0, entrada_b};
    alu_res = '0;
    alu_flg = '0;
    unique case (1'b1)
      (operacion == OP_AND): alu_res = entrada_a & entrada_b;
      (operacion == OP_OR):  alu_res = entrada_a | entrada_b;
      (operacion == OP_XOR): alu_res = entrada_a ^ entrada_b;
      (operacion == OP_ADD): begin
        alu_res         = add_w[MSB:0];
        alu_flg[FLAG_C] = add_w[N_BITS];
        alu_flg[FLAG_V] = (entrada_a[MSB] == entrada_b[MSB])
                       && (alu_res[MSB] != entrada_a[MSB]);
      end
      (operacion == OP_SUB): begin
        alu_res         = sub_w[MSB:0];
        alu_flg[FLAG_C] = ~sub_w[N_BITS];
        alu_flg[FLAG_V] = (entrada_a[MSB] != entrada_b[MSB])
                       && (alu_res[MSB] != entrada_a[MSB]);
      end
      default: ;
    endcase
    alu_flg[FLAG_Z] = (alu_res == '0);
    alu_flg[FLAG_N] = alu_res[MSB];
  end

  // FSM next state and result capture
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    hi_d    = hi_q;
    flg_d   = flg_q;
`ifdef ALU_SECUENCIAL_MUL_EN
    mul_start = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = DONE;
          res_d   = alu_res;
          hi_d    = '0;
          flg_d   = alu_flg;
`ifdef ALU_SECUENCIAL_MUL_EN
          if (operacion == OP_MUL) begin
            state_d   = BUSY;
            mul_start = 1'b1;
          end
`endif
        end
      end
      BUSY: begin
`ifdef ALU_SECUENCIAL_MUL_EN
        if (mul_done) begin
          state_d         = DONE;
          res_d           = mul_prod[MSB:0];
          hi_d            = mul_prod[2*N_BITS-1:N_BITS];
          flg_d           = '0;
          flg_d[FLAG_C]   = (hi_d != '0);
          flg_d[FLAG_N]   = mul_prod[2*N_BITS-1];
          flg_d[FLAG_Z]   = (mul_prod == '0);
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset overrides any handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      hi_q    <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      flg_q   <= flg_d;
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign out_valid      = (state_q == DONE);
  assign resultado      = res_q;
  assign resultado_alto = hi_q;
  assign banderas       = flg_q;

endmodule

// File: tb/tb_alu_secuencial.sv
// Self-checking bench for alu_secuencial (N_BITS=8).
// Follows ALU_SECUENCIAL_MUL_EN to pick the expected MUL behaviour.
module tb_alu_secuencial;

  localparam int W = 8;
`ifdef ALU_SECUENCIAL_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] entrada_a = '0;
  logic [W-1:0] entrada_b = '0;
  logic [2:0]   operacion = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] resultado;
  logic [W-1:0] resultado_alto;
  logic [3:0]   banderas;
  logic         out_valid;
  logic         out_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_secuencial #(.N_BITS(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .entrada_a      (entrada_a),
    .entrada_b      (entrada_b),
    .operacion      (operacion),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .resultado      (resultado),
    .resultado_alto (resultado_alto),
    .banderas       (banderas),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  // Reference: plain integer arithmetic; flags packed {V,C,N,Z}
  function automatic void model(
    input  logic [W-1:0] a, b,
    input  logic [2:0]   op,
    output logic [W-1:0] lo, hi,
    output logic [3:0]   fl,
    output int           lat
  );
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int smax = (1 << (W - 1)) - 1;
    int smin = -(1 << (W - 1));
    int r = 0;
    int s = 0;
    bit c = 0;
    bit v = 0;
    bit rsv = 0;
    longint p;
    lat = 1;
    hi = '0;
    case (op)
      3'd0: r = ua & ub;
      3'd1: r = ua | ub;
      3'd2: r = ua ^ ub;
      3'd3: begin
        r = ua + ub;
        c = (r >> W) != 0;
        s = sa + sb;
        v = (s > smax) || (s < smin);
      end
      3'd4: begin
        r = ua - ub;
        c = ua >= ub;
        s = sa - sb;
        v = (s > smax) || (s < smin);
      end
      3'd5: rsv = !MUL_ON;
      default: rsv = 1;
    endcase
    if (rsv) begin
      lo = '0;
      fl = 4'b0001;
    end else if (op == 3'd5) begin
      p   = longint'(ua) * longint'(ub);
      lo  = W'(p);
      hi  = W'(p >> W);
      fl  = {1'b0, hi != 0, hi[W-1], p == 0};
      lat = W + 1;
    end else begin
      lo = W'(r);
      fl = {v, c, lo[W-1], lo == 0};
    end
  endfunction

  // Issue one request from IDLE, wait for the result, then consume it
  task automatic run_op(
    input  logic [W-1:0] a, b,
    input  logic [2:0]   op,
    input  int           hold,
    output logic [W-1:0] lo, hi,
    output logic [3:0]   fl,
    output int           lat,
    output logic         acc
  );
    acc = in_ready;
    entrada_a = a;
    entrada_b = b;
    operacion = op;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    entrada_a = W'($urandom);
    entrada_b = W'($urandom);
    operacion = 3'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    lo = resultado;
    hi = resultado_alto;
    fl = banderas;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        resultado !== '0 || resultado_alto !== '0 ||
        banderas !== 4'b0000) begin
      n_err++;
      $display("FAIL reset: rdy=%b vld=%b res=%h hi=%h fl=%b",
               in_ready, out_valid, resultado,
               resultado_alto, banderas);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[4] = '{8'h7F, 8'h05, 8'h00, 8'hFF};
    logic [W-1:0] tb[4] = '{8'h01, 8'h05, 8'h01, 8'hFF};
    logic [2:0]   to[4] = '{3'd3, 3'd4, 3'd4, 3'd5};
    logic [W-1:0] sl[4] = '{8'h80, 8'h00, 8'hFF, 8'h01};
    logic [W-1:0] sh[4] = '{8'h00, 8'h00, 8'h00, 8'hFE};
    logic [3:0]   sf[4] = '{4'b1010, 4'b0101, 4'b0010, 4'b0110};
    int           sa[4] = '{1, 1, 1, W + 1};
    logic [W-1:0] lo, hi, el, eh;
    logic [3:0]   fl, ef;
    int           lat, elat;
    logic         acc;
    for (int i = 0; i < 4; i++) begin
      model(ta[i], tb[i], to[i], el, eh, ef, elat);
      if (to[i] == 3'd5 && !MUL_ON) begin
        sl[i] = '0; sh[i] = '0;
        sf[i] = 4'b0001; sa[i] = 1;
      end
      run_op(ta[i], tb[i], to[i], 0, lo, hi, fl, lat, acc);
      n_vec++;
      if (acc !== 1'b1 || lo !== sl[i] || hi !== sh[i] ||
          fl !== sf[i] || lat != sa[i]) begin
        n_err++;
        $display("FAIL directed%0d: got %h/%h/%b lat%0d acc%b want %h/%h/%b lat%0d",
                 i, hi, lo, fl, lat, acc, sh[i], sl[i], sf[i], sa[i]);
      end
      n_vec++;
      if (lo !== el || hi !== eh || fl !== ef || lat != elat) begin
        n_err++;
        $display("FAIL directed_model%0d: got %h/%h/%b lat%0d want %h/%h/%b lat%0d",
                 i, hi, lo, fl, lat, eh, el, ef, elat);
      end
    end
  endtask

  task automatic test_hold();
    int w = 0;
    entrada_a = 8'hF0;
    entrada_b = 8'h3C;
    operacion = 3'd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    entrada_a = 8'hFF;
    entrada_b = 8'h0F;
    operacion = 3'd1;
    while (out_valid !== 1'b1 && w < 64) begin
      @(posedge clk); #1;
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          resultado !== 8'h30 || banderas !== 4'b0000 ||
          resultado_alto !== 8'h00) begin
        n_err++;
        $display("FAIL hold%0d: vld=%b rdy=%b res=%h fl=%b want 1/0/30/0000",
                 i, out_valid, in_ready, resultado, banderas);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold_release: rdy=%b vld=%b want 1/0",
               in_ready, out_valid);
    end
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold_ignored: vld=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] el, eh, lo, hi;
    logic [3:0]   ef, fl;
    int           elat, lat;
    logic         acc;
    model(8'hFF, 8'hFF, 3'd5, el, eh, ef, elat);
    entrada_a = 8'hFF;
    entrada_b = 8'hFF;
    operacion = 3'd5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== (elat <= 4)) begin
      n_err++;
      $display("FAIL abort_pre: vld=%b want %b",
               out_valid, elat <= 4);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        resultado !== '0 || resultado_alto !== '0 ||
        banderas !== '0) begin
      n_err++;
      $display("FAIL abort: rdy=%b vld=%b res=%h hi=%h fl=%b want 1/0/0/0/0",
               in_ready, out_valid, resultado,
               resultado_alto, banderas);
    end
    repeat (W + 2) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL abort_leak: vld=%b want 0", out_valid);
      end
    end
    run_op(8'hAA, 8'hFF, 3'd2, 1, lo, hi, fl, lat, acc);
    n_vec++;
    if (lo !== 8'h55 || hi !== 8'h00 || fl !== 4'b0000 ||
        lat != 1 || acc !== 1'b1) begin
      n_err++;
      $display("FAIL abort_xor: got %h/%h/%b lat%0d want 00/55/0000 lat1",
               hi, lo, fl, lat);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, lo, hi, el, eh;
    logic [2:0]   op;
    logic [3:0]   fl, ef;
    int           lat, elat;
    logic         acc;
    for (int i = 0; i < 40; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      op = 3'($urandom);
      if (i < 8) op = 3'(i);
      model(a, b, op, el, eh, ef, elat);
      run_op(a, b, op, $urandom_range(0, 3),
             lo, hi, fl, lat, acc);
      n_vec++;
      if (acc !== 1'b1 || lo !== el || hi !== eh ||
          fl !== ef || lat != elat) begin
        n_err++;
        $display("FAIL random%0d op%0d %h,%h: got %h/%h/%b lat%0d want %h/%h/%b lat%0d",
                 i, op, a, b, hi, lo, fl, lat, eh, el, ef, elat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q_lo[$];
    logic [3:0]   q_fl[$];
    logic [W-1:0] el, eh, gl;
    logic [3:0]   ef, gf;
    int           elat;
    int           accepts = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      entrada_a = W'($urandom);
      entrada_b = W'($urandom);
      operacion = 3'($urandom_range(0, 6));
      if (operacion == 3'd5) operacion = 3'd7;
      in_valid = 1'b1;
      if (in_ready === 1'b1) begin
        model(entrada_a, entrada_b, operacion,
              el, eh, ef, elat);
        q_lo.push_back(el);
        q_fl.push_back(ef);
        accepts++;
      end
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        gl = q_lo.size() > 0 ? q_lo.pop_front() : 'x;
        gf = q_fl.size() > 0 ? q_fl.pop_front() : 'x;
        n_vec++;
        if (resultado !== gl || banderas !== gf) begin
          n_err++;
          $display("FAIL b2b%0d: got %h/%b want %h/%b",
                   i, resultado, banderas, gl, gf);
        end
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if (accepts != 12 || q_lo.size() != 0) begin
      n_err++;
      $display("FAIL b2b_rate: accepts=%0d left=%0d want 12/0",
               accepts, q_lo.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
